frame_pixel_tx: RTL and testbench

- Frame source that reads a stored frame row-major from a synchronous pixel memory and drives the AXI-stream-style pixel interface consumed by the filter line buffer: data, valid, ready, 2-bit TUSER.
- Sits upstream of the line buffer, at the other end of its s_tvalid/s_tready/TUSER/in_d0 input.
- Absorbs the 1-cycle memory read latency under backpressure with a 2-entry output queue.
- Sustains 1 pixel/cycle when ready is held high.

---
 rtl/frame_pixel_tx_if.sv | 26 ++
 rtl/frame_pixel_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_frame_pixel_tx.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pixel_tx_if.sv
// frame_pixel_tx_if: AXI-stream-style pixel beat bundle between the frame
// source and the filter line buffer (data, valid, ready, 2-bit TUSER marker).
interface frame_pixel_tx_if #(
  parameter int pix_depth = 4
);
  logic                 m_tvalid;
  logic                 m_tready;
  logic [pix_depth-1:0] m_tdata;
  logic [1:0]           TUSER;

  // Frame source drives the beat, consumer returns ready
  modport master (
    output m_tvalid,
    output m_tdata,
    output TUSER,
    input  m_tready
  );

  // Line buffer side
  modport slave (
    input  m_tvalid,
    input  m_tdata,
    input  TUSER,
    output m_tready
  );
endinterface

// File: rtl/frame_pixel_tx.sv
// frame_pixel_tx: reads a stored frame row-major from a synchronous pixel
// memory (1-cycle read latency) and streams it as pixel beats with TUSER
// line/frame markers. A 2-entry output queue absorbs the read latency under
// backpressure while still sustaining one beat per cycle with ready high.
//
// Optional feature macro: FRAME_PIXEL_TX_HPAD_EN
//   When defined, every line is widened by add_cells replicated edge pixels
//   on each side; the replicas are produced by re-reading the edge address.
module frame_pixel_tx #(
  parameter int pix_depth    = 4,
  parameter int frame_width  = 10,
  parameter int frame_height = 10,
  parameter int filter_size  = 5,
  parameter int add_cells    = (filter_size - 1) / 2,
  parameter int addr_width   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  mem_rd_en,
  output logic [addr_width-1:0] mem_addr,
  input  logic [pix_depth-1:0]  mem_rd_data,
  frame_pixel_tx_if.master      pix
);

`ifdef FRAME_PIXEL_TX_HPAD_EN
  localparam int PAD = add_cells;
`else
  localparam int PAD = 0 * add_cells;
`endif

  // Emitted beats per line, including any horizontal padding
  localparam int LINE_LEN = frame_width + 2 * PAD;
  localparam int PW       = $clog2(LINE_LEN + 1);
  localparam int YW       = $clog2(frame_height + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         pos_q;
  logic [YW-1:0]         y_q;
  logic [addr_width-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  inflight_q;
  logic [1:0]            tagPend_q;

  logic [1:0]            occ_q,   occ_d;
  logic [pix_depth-1:0]  data0_q, data0_d;
  logic [pix_depth-1:0]  data1_q, data1_d;
  logic [1:0]            user0_q, user0_d;
  logic [1:0]            user1_q, user1_d;

  logic                  pop;
  logic                  push;
  logic [2:0]            level;
  logic                  rdEn;
  logic                  lineEnd;
  logic                  lastRow;
  logic                  advance;
  logic [1:0]            issueTag;
  int                    posIdx;

  // Read issue decision, beat position decode and TUSER tag for the read
  // being issued this cycle. A read is only issued if its data is
  // guaranteed a queue slot once it returns next cycle.
  always_comb begin
    pop     = (occ_q != 2'd0) && pix.m_tready;
    push    = inflight_q;
    level   = {1'b0, occ_q} + {2'b00, inflight_q};
    rdEn    = (state_q == RUN) && (level < (3'd2 + {2'b00, pop}));
    lineEnd = (pos_q == PW'(LINE_LEN - 1));
    lastRow = (y_q == YW'(frame_height - 1));
    posIdx  = int'(pos_q);
    // The address moves on only when the next beat shows a different pixel:
    // inside the real pixel run, or from the line's last beat to the next line.
    advance = lineEnd || ((posIdx >= PAD) && (posIdx < PAD + frame_width - 1));
    if (pos_q == '0) begin
      issueTag = (y_q == '0) ? 2'b11 : 2'b01;
    end else if (lineEnd) begin
      issueTag = 2'b10;
    end else begin
      issueTag = 2'b00;
    end
  end

  // Control FSM with read-address/position counters and registered status.
  // Counters are zeroed once the last read is issued so the address rests at 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      tagPend_q  <= 2'b00;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rdEn;
      if (rdEn) begin
        tagPend_q <= issueTag;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            pos_q   <= '0;
            y_q     <= '0;
            addr_q  <= '0;
          end
        end
        RUN: begin
          if (rdEn) begin
            if (lineEnd) begin
              pos_q <= '0;
              if (lastRow) begin
                y_q     <= '0;
                addr_q  <= '0;
                state_q <= DRAIN;
              end else begin
                y_q    <= y_q + YW'(1);
                addr_q <= addr_q + addr_width'(1);
              end
            end else begin
              pos_q <= pos_q + PW'(1);
              if (advance) begin
                addr_q <= addr_q + addr_width'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (pop && (occ_q == 2'd1) && !inflight_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next state of the 2-entry output queue: entry 0 is the head that drives
  // the beat, returning read data lands behind whatever is still queued.
  always_comb begin
    occ_d   = occ_q + {1'b0, push} - {1'b0, pop};
    data0_d = data0_q;
    data1_d = data1_q;
    user0_d = user0_q;
    user1_d = user1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = mem_rd_data;
          user0_d = tagPend_q;
        end else begin
          data1_d = mem_rd_data;
          user1_d = tagPend_q;
        end
      end
      2'b01: begin
        data0_d = data1_q;
        user0_d = user1_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = mem_rd_data;
          user0_d = tagPend_q;
        end else begin
          data0_d = data1_q;
          user0_d = user1_q;
          data1_d = mem_rd_data;
          user1_d = tagPend_q;
        end
      end
      default: begin
        data0_d = data0_q;
      end
    endcase
  end

  // Output queue registers; clearing them on reset also drops any read
  // that was still in flight, since inflight_q is cleared alongside.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q   <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      user0_q <= 2'b00;
      user1_q <= 2'b00;
    end else begin
      occ_q   <= occ_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      user0_q <= user0_d;
      user1_q <= user1_d;
    end
  end

  assign pix.m_tvalid = (occ_q != 2'd0);
  assign pix.m_tdata  = data0_q;
  assign pix.TUSER    = user0_q;
  assign mem_rd_en    = rdEn;
  assign mem_addr     = addr_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_frame_pixel_tx.sv
// tb_frame_pixel_tx: directed bench for frame_pixel_tx with a memory model
// returning mem_addr[3:0] and a scoreboard of expected beats per frame.
module tb_frame_pixel_tx;

  localparam int FW = 10;
  localparam int FH = 10;
`ifdef FRAME_PIXEL_TX_HPAD_EN
  localparam int PAD = 2;
`else
  localparam int PAD = 0;
`endif
  localparam int L         = FW + 2 * PAD;
  localparam int FRAME_LEN = L * FH;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [3:0] mem_rd_data = 4'h0;

  frame_pixel_tx_if #(.pix_depth(4)) pixIf ();

  frame_pixel_tx #(
    .pix_depth(4), .frame_width(FW), .frame_height(FH),
    .filter_size(5), .addr_width(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy),
    .frame_done(frame_done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .pix(pixIf.master)
  );

  always #5 clock = ~clock;

  // Synchronous pixel memory: pixel at address a holds a mod 16
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem_addr[3:0];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [5:0] sb[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {tuser, data} for every beat of one frame
  task automatic pushFrame();
    for (int k = 0; k < FRAME_LEN; k++) begin
      int line, p, x;
      logic [1:0] u;
      logic [3:0] d;
      line = k / L;
      p = k % L;
      x = p - PAD;
      if (x < 0) x = 0;
      if (x > FW - 1) x = FW - 1;
      d = 4'((line * FW + x) % 16);
      if (p == 0) u = (line == 0) ? 2'b11 : 2'b01;
      else if (p == L - 1) u = 2'b10;
      else u = 2'b00;
      sb.push_back({u, d});
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start = s;
    pixIf.m_tready = r;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (!frame_done && cycles < budget) begin
      nextCycle();
      cycles++;
    end
    checkOutput("frame_done_seen", frame_done, 1);
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, outstanding reads
  logic       prevStall = 1'b0;
  logic [3:0] prevData;
  logic [1:0] prevUser;
  int         outstanding = 0;

  always @(negedge clock) begin
    logic [5:0] e;
    logic hs;
    if (reset) begin
      prevStall = 1'b0;
      outstanding = 0;
    end else begin
      hs = pixIf.m_tvalid && pixIf.m_tready;
      if (prevStall) begin
        checkOutput("stall_valid", pixIf.m_tvalid, 1);
        checkOutput("stall_data", pixIf.m_tdata, prevData);
        checkOutput("stall_tuser", pixIf.TUSER, prevUser);
      end
      if (hs) begin
        checkOutput("beat_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("beat_data", pixIf.m_tdata, e[3:0]);
          checkOutput("beat_tuser", pixIf.TUSER, e[5:4]);
        end
      end
      if (mem_rd_en) outstanding++;
      if (hs) outstanding--;
      checkOutput("occ_plus_inflight_le2", outstanding <= 2, 1);
      prevStall = pixIf.m_tvalid && !pixIf.m_tready;
      prevData  = pixIf.m_tdata;
      prevUser  = pixIf.TUSER;
    end
  end

  initial begin
    int cyc;
    int reads;
    int runLen;
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    checkOutput("rst_tvalid", pixIf.m_tvalid, 0);
    checkOutput("rst_tdata", pixIf.m_tdata, 0);
    checkOutput("rst_tuser", pixIf.TUSER, 0);
    checkOutput("rst_rd_en", mem_rd_en, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", frame_done, 0);

    // Full-rate frame: latency and frame_done timing
    pushFrame();
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    start = 1'b0;
    checkOutput("c1_rd_en", mem_rd_en, 1);
    checkOutput("c1_addr", mem_addr, 0);
    checkOutput("c1_busy", busy, 1);
    nextCycle();
    checkOutput("c2_tvalid", pixIf.m_tvalid, 0);
    nextCycle();
    checkOutput("c3_tvalid", pixIf.m_tvalid, 1);
    checkOutput("c3_tdata", pixIf.m_tdata, 0);
    checkOutput("c3_tuser", pixIf.TUSER, 3);
    waitDone(FRAME_LEN + 20, cyc);
    checkOutput("done_cycle", cyc + 3, 3 + FRAME_LEN);
    checkOutput("done_busy_low", busy, 0);
    checkOutput("sb_empty_f1", sb.size(), 0);
    nextCycle();
    checkOutput("done_one_pulse", frame_done, 0);

    // Random backpressure
    pushFrame();
    applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    nextCycle();
    start = 1'b0;
    cyc = 0;
    while (!frame_done && cyc < 5000) begin
      pixIf.m_tready = 1'($urandom_range(0, 1));
      nextCycle();
      cyc++;
    end
    checkOutput("rand_done_seen", frame_done, 1);
    checkOutput("sb_empty_rand", sb.size(), 0);

    // Ready held low: exactly two reads, head holds pixel 0, then full rate
    pushFrame();
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    start = 1'b0;
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_rd_en) reads++;
      nextCycle();
    end
    checkOutput("stall_reads", reads, 2);
    checkOutput("stall_head_valid", pixIf.m_tvalid, 1);
    checkOutput("stall_head_data", pixIf.m_tdata, 0);
    checkOutput("stall_head_tuser", pixIf.TUSER, 3);
    pixIf.m_tready = 1'b1;
    runLen = 0;
    for (int i = 0; i < 20; i++) begin
      if (pixIf.m_tvalid) runLen++;
      nextCycle();
    end
    checkOutput("resume_rate", runLen, 20);
    waitDone(FRAME_LEN + 20, cyc);
    checkOutput("sb_empty_stall", sb.size(), 0);
    nextCycle();

    // Ignored start pulses mid-frame, then start in the frame_done cycle
    pushFrame();
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    start = 1'b0;
    cyc = 1;
    while (!frame_done && cyc < FRAME_LEN + 20) begin
      start = (cyc == 3 + 5) || (cyc == 3 + 50);
      nextCycle();
      cyc++;
    end
    start = 1'b0;
    checkOutput("f4_done_cycle", cyc, 3 + FRAME_LEN);
    pushFrame();
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    checkOutput("b2b_rd_en", mem_rd_en, 1);
    checkOutput("b2b_addr", mem_addr, 0);
    checkOutput("b2b_busy", busy, 1);
    waitDone(FRAME_LEN + 20, cyc);
    checkOutput("sb_empty_b2b", sb.size(), 0);
    nextCycle();

    // Reset during handshake of beat 37
    pushFrame();
    applyStimulus(1'b1, 1'b1);
    nextCycle();
    start = 1'b0;
    repeat (39) nextCycle();
    checkOutput("pre_rst_tvalid", pixIf.m_tvalid, 1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    sb.delete();
    checkOutput("mid_rst_tvalid", pixIf.m_tvalid, 0);
    checkOutput("mid_rst_tdata", pixIf.m_tdata, 0);
    checkOutput("mid_rst_tuser", pixIf.TUSER, 0);
    checkOutput("mid_rst_rd_en", mem_rd_en, 0);
    checkOutput("mid_rst_addr", mem_addr, 0);
    checkOutput("mid_rst_busy", busy, 0);
    nextCycle();
    checkOutput("late_ret_ignored", pixIf.m_tvalid, 0);
    nextCycle();
    checkOutput("late_ret_ignored2", pixIf.m_tvalid, 0);
    pushFrame();
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    checkOutput("post_rst_addr", mem_addr, 0);
    checkOutput("post_rst_rd_en", mem_rd_en, 1);
    waitDone(FRAME_LEN + 20, cyc);
    checkOutput("sb_empty_post_rst", sb.size(), 0);
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
